// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba multiplier UART front-end.
// Holds the receive-frame state encoding and the default sizing constants.
package karatsuba_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_RECEIVE = 2'd1,
        RX_STORE   = 2'd2,
        RX_DONE    = 2'd3
    } rx_state_t;

    // 100 MHz clock, 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int NUM_BYTES            = 64;

endpackage

// File: rtl/karatsuba_rxd_rx_base.sv
// rx_base: 8N1 UART byte receiver.
// Two-flop synchroniser, falling-edge start detect with a half-bit glitch
// re-check, mid-bit sampling LSB first, and a stop-bit validity flag.
// It returns to idle right at the stop-bit sample so back-to-back frames work.
module rx_base
    import karatsuba_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Rx,
    output logic       o_data_avail,
    output logic [7:0] o_data_byte,
    output logic       o_stop_ok,
    output logic       o_active
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;

    logic          rx_meta, rx_sync, rx_dly;
    bit_state_t    st;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronise the async line; rx_dly is only for falling-edge detection.
    // Everything resets to the idle-high level so reset never fakes a start.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_dly  <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_dly  <= rx_sync;
        end
    end

    // Bit timer / frame walker: start re-check at half a bit, then one sample per bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            st           <= B_IDLE;
            tmr          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            o_data_avail <= 1'b0;
            o_data_byte  <= '0;
            o_stop_ok    <= 1'b0;
        end else begin
            o_data_avail <= 1'b0;
            case (st)
                B_IDLE: begin
                    if (rx_dly && !rx_sync) begin
                        st  <= B_START;
                        tmr <= '0;
                    end
                end
                B_START: begin
                    if (tmr == TW'(CLKS_PER_BIT/2 - 1)) begin
                        tmr <= '0;
                        if (rx_sync) begin
                            st <= B_IDLE;       // line back high: glitch, not a start bit
                        end else begin
                            st      <= B_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                B_DATA: begin
                    if (tmr == TW'(CLKS_PER_BIT - 1)) begin
                        tmr     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) st <= B_STOP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                B_STOP: begin
                    if (tmr == TW'(CLKS_PER_BIT - 1)) begin
                        tmr          <= '0;
                        o_data_avail <= 1'b1;
                        o_stop_ok    <= rx_sync;
                        o_data_byte  <= shreg;
                        st           <= B_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: st <= B_IDLE;
            endcase
        end
    end

    assign o_active = (st != B_IDLE);

endmodule

// File: rtl/karatsuba_rxd.sv
// karatsuba_rxd: UART receive front-end for the Karatsuba modular multiplier.
// Arms on start, assembles NUM_BYTES bytes (LSB byte first) into D, then
// raises a sticky done. One operand per reset.
// Optional feature macro: KARATSUBA_RXD_TIMEOUT_EN adds an inter-byte idle
// timeout that aborts the frame back to IDLE with an err pulse.
module karatsuba_rxd #(
    parameter int CLKS_PER_BIT = karatsuba_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int NUM_BYTES    = karatsuba_pkg::NUM_BYTES,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   Rx,
    output logic [8*NUM_BYTES-1:0] D,
    output logic                   done,
    output logic                   busy,
    output logic                   err
);
    import karatsuba_pkg::*;

    localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    rx_state_t     state;
    logic [CW-1:0] count;
    logic [7:0]    byte_q;

    logic          rx_avail;
    logic [7:0]    rx_byte;
    logic          rx_stop_ok;
    logic          rx_active;

`ifdef KARATSUBA_RXD_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CLKS + 1);
    logic [TOW-1:0] tcnt;
`endif

    rx_base #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock        (clock),
        .reset        (reset),
        .Rx           (Rx),
        .o_data_avail (rx_avail),
        .o_data_byte  (rx_byte),
        .o_stop_ok    (rx_stop_ok),
        .o_active     (rx_active)
    );

    // Frame FSM: byte counter, operand register and registered status outputs.
    // done is raised on the STORE->DONE edge so it appears with DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RX_IDLE;
            count  <= '0;
            byte_q <= '0;
            D      <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
`ifdef KARATSUBA_RXD_TIMEOUT_EN
            tcnt   <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (start && !done) begin
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RX_RECEIVE;
`ifdef KARATSUBA_RXD_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
                end
                RX_RECEIVE: begin
                    if (rx_avail) begin
`ifdef KARATSUBA_RXD_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (rx_stop_ok) begin
                            byte_q <= rx_byte;
                            state  <= RX_STORE;
                        end else begin
                            err <= 1'b1;        // bad stop bit: drop byte, keep count
                        end
                    end
`ifdef KARATSUBA_RXD_TIMEOUT_EN
                    else if (tcnt == TOW'(TIMEOUT_CLKS - 1)) begin
                        err   <= 1'b1;
                        count <= '0;
                        busy  <= 1'b0;
                        tcnt  <= '0;
                        state <= RX_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                RX_STORE: begin
                    D[{count, 3'b000} +: 8] <= byte_q;
                    if (count == CW'(NUM_BYTES - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= RX_DONE;
                    end else begin
                        count <= count + 1'b1;
                        state <= RX_RECEIVE;
`ifdef KARATSUBA_RXD_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
                end
                RX_DONE: begin
                    done  <= 1'b1;
                    state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // rx_active is informational only; TIMEOUT_CLKS matters only with the timeout built in.
    logic unused_ok;
    assign unused_ok = rx_active ^ (TIMEOUT_CLKS > 0);

endmodule

// File: tb/tb_karatsuba_rxd.sv
// Directed bench for karatsuba_rxd at CLKS_PER_BIT=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// The timeout scenario runs only when KARATSUBA_RXD_TIMEOUT_EN is defined.
module tb_karatsuba_rxd;

    localparam int CPB = 4;
    localparam int NB  = 64;
    localparam int DW  = 8 * NB;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          Rx;
    logic [DW-1:0] D;
    logic          done, busy, err;

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;
    int e0;
    logic [DW-1:0] exp_d;

    karatsuba_rxd #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_CLKS(80)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .Rx    (Rx),
        .D     (D),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (err) err_cnt <= err_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        Rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        Rx = stop;
        repeat (CPB) @(negedge clock);
        Rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        Rx = 1'b1;
        repeat (n * CPB) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; Rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; Rx = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checks++; if (D !== '0)    begin errors++; $display("FAIL reset_D got %h exp 0", D); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_no_start();
        for (int k = 0; k < NB; k++) send_frame(8'(k), 1'b1);
        idle_bits(2);
        checks++; if (D !== '0)      begin errors++; $display("FAIL nostart_D got %h exp 0", D); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nostart_done got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nostart_busy got %b exp 0", busy); end
    endtask

    task automatic test_full_frame();
        for (int k = 0; k < NB; k++) exp_d[8*k +: 8] = 8'(k);
        start = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_armed_busy got %b exp 1", busy); end
        e0 = err_cnt;
        for (int k = 0; k < NB - 1; k++) send_frame(8'(k), 1'b1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_early63 got %b exp 0", done); end
        send_frame(8'(NB - 1), 1'b1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_before_stop got %b exp 0", done); end
        repeat (5) @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b exp 0", busy); end
        checks++; if (D !== exp_d)   begin errors++; $display("FAIL full_D got %h exp %h", D, exp_d); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL full_err_pulses got %0d exp 0", err_cnt - e0); end
    endtask

    task automatic test_after_done();
        start = 1'b1;
        for (int k = 0; k < NB; k++) send_frame(~8'(k), 1'b1);
        idle_bits(2);
        checks++; if (D !== exp_d)   begin errors++; $display("FAIL after_D got %h exp %h", D, exp_d); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL after_done got %b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_busy got %b exp 0", busy); end
    endtask

    task automatic test_framing_err();
        do_reset();
        start = 1'b1;
        @(negedge clock);
        e0 = err_cnt;
        for (int k = 0; k < 5; k++) send_frame(8'(k), 1'b1);
        send_frame(8'hAA, 1'b0);
        idle_bits(2);
        for (int k = 5; k < NB - 1; k++) send_frame(8'(k), 1'b1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ferr_done_early got %b exp 0", done); end
        send_frame(8'(NB - 1), 1'b1);
        repeat (5) @(negedge clock);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL ferr_err_pulses got %0d exp 1", err_cnt - e0); end
        checks++; if (D[47:40] !== 8'h05) begin errors++; $display("FAIL ferr_byte5 got %h exp 05", D[47:40]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ferr_done got %b exp 1", done); end
        checks++; if (D !== exp_d)   begin errors++; $display("FAIL ferr_D got %h exp %h", D, exp_d); end
    endtask

    task automatic test_glitch_reset();
        do_reset();
        start = 1'b1;
        @(negedge clock);
        Rx = 1'b0;
        @(negedge clock);
        Rx = 1'b1;
        idle_bits(3);
        for (int k = 0; k < 10; k++) send_frame(8'(k + 8'h40), 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy10 got %b exp 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL glitch_done10 got %b exp 0", done); end
        // reset in the middle of the 11th byte
        Rx = 1'b0;
        repeat (3 * CPB) @(negedge clock);
        reset = 1'b1; start = 1'b0; Rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (D !== '0)      begin errors++; $display("FAIL rst_mid_D got %h exp 0", D); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL rst_mid_err got %b exp 0", err); end
        idle_bits(3);
        for (int k = 0; k < NB; k++) exp_d[8*k +: 8] = 8'(3 * k + 1);
        start = 1'b1;
        @(negedge clock);
        Rx = 1'b0;
        @(negedge clock);
        Rx = 1'b1;
        idle_bits(3);
        for (int k = 0; k < NB - 1; k++) send_frame(8'(3 * k + 1), 1'b1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL glitch_done63 got %b exp 0", done); end
        send_frame(8'(3 * (NB - 1) + 1), 1'b1);
        repeat (5) @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL glitch_done got %b exp 1", done); end
        checks++; if (D !== exp_d)   begin errors++; $display("FAIL glitch_D got %h exp %h", D, exp_d); end
    endtask

`ifdef KARATSUBA_RXD_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 3; k++) send_frame(8'(k + 8'h10), 1'b1);
        e0 = err_cnt;
        repeat (70) @(negedge clock);
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL tmo_early_err got %0d exp 0", err_cnt - e0); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL tmo_busy_wait got %b exp 1", busy); end
        repeat (20) @(negedge clock);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL tmo_err got %0d exp 1", err_cnt - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tmo_done got %b exp 0", done); end
        for (int k = 0; k < NB; k++) exp_d[8*k +: 8] = 8'(k) ^ 8'h5A;
        start = 1'b1;
        @(negedge clock);
        for (int k = 0; k < NB; k++) send_frame(8'(k) ^ 8'h5A, 1'b1);
        repeat (5) @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_retry_done got %b exp 1", done); end
        checks++; if (D !== exp_d)   begin errors++; $display("FAIL tmo_retry_D got %h exp %h", D, exp_d); end
    endtask
`endif

    initial begin
        test_reset();
        test_no_start();
        test_full_frame();
        test_after_done();
        test_framing_err();
        test_glitch_reset();
`ifdef KARATSUBA_RXD_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
